// File: rtl/clk_div_ctrl.sv
// Run-time programmable clock divider controller: start/stop sequencing with
// divisor changes that take effect only on period boundaries.
module clk_div_ctrl #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             cfg_valid,
    input  logic [WIDTH-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             tick,
    output logic             div_out,
    output logic             busy,
    output logic [WIDTH-1:0] active_div,
    output logic [1:0]       state_dbg
);

    // Handshake: cfg_div transfers on any rising edge where cfg_valid && cfg_ready.
    // cfg_ready only drops while an accepted divisor waits for its period boundary.

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        RUN      = 2'b01,
        STOPPING = 2'b10
    } state_t;

    localparam logic [WIDTH-1:0] DIV_RESET = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] DIV_MIN   = WIDTH'(2);
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
    localparam logic [WIDTH:0]   ONE_WIDE  = (WIDTH+1)'(1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_next;
    logic [WIDTH-1:0] pending_div;
    logic             pending;
    logic             pending_next;
    logic [WIDTH-1:0] div_next;
    logic [WIDTH:0]   half_next;
    logic             wave_next;
    logic             cfg_fire;
    logic             cfg_bad;
    logic             cfg_take;
    logic             at_boundary;

    assign cfg_ready   = !pending;
    assign cfg_fire    = cfg_valid && cfg_ready;
    assign cfg_bad     = cfg_div < DIV_MIN;
    assign cfg_take    = cfg_fire && !cfg_bad;
    assign at_boundary = (state != IDLE) && (cnt == active_div - ONE);
    assign state_dbg   = state;

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start && !stop) state_next = RUN;
            end
            RUN: begin
                if (stop) state_next = STOPPING;
            end
            STOPPING: begin
                if (start && !stop)   state_next = RUN;
                else if (at_boundary) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // A divisor accepted while idle, or on the final edge of a stop, has no
    // running period to wait for, so it takes effect immediately.
    always_comb begin
        div_next = active_div;
        if (cfg_take && (state == IDLE || state_next == IDLE)) begin
            div_next = cfg_div;
        end else if (at_boundary && pending) begin
            div_next = pending_div;
        end
    end

    always_comb begin
        if (pending) pending_next = !at_boundary;
        else         pending_next = cfg_take && (state != IDLE) && (state_next != IDLE);
    end

    always_comb begin
        if (state == IDLE || state_next == IDLE || at_boundary) cnt_next = '0;
        else                                                    cnt_next = cnt + ONE;
    end

    // Widened by one bit so the half-period stays exact for the largest divisor.
    assign half_next = ({1'b0, div_next} + ONE_WIDE) >> 1;
    assign wave_next = (state_next != IDLE) && ({1'b0, cnt_next} < half_next);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            active_div  <= DIV_RESET;
            pending     <= 1'b0;
            pending_div <= DIV_RESET;
            tick        <= 1'b0;
            div_out     <= 1'b0;
            cfg_err     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            active_div <= div_next;
            pending    <= pending_next;
            if (pending_next && !pending) begin
                pending_div <= cfg_div;
            end
            tick    <= at_boundary;
            div_out <= wave_next;
            cfg_err <= cfg_fire && cfg_bad;
            busy    <= (state_next != IDLE);
        end
    end

endmodule

// File: doc/clk_div_ctrl.md
Name: clk_div_ctrl

Overview:
Run-time controller for the team's clock-division datapath. It sequences one programmable divider: start, stop, and glitch-free divisor changes applied only on period boundaries. Outputs are a one-cycle tick enable and a registered near-50% divided waveform, both synchronous to clk. This block replaces fixed ripple/counter dividers wherever software or an FSM must change the ratio at run time.

Parameters:
WIDTH, 8, width of divisor and period counter
DEFAULT_DIV, 2, active divisor after reset; must be >= 2 and < 2^WIDTH

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  run request, level sampled each edge
stop  in  1  stop request, level sampled each edge
cfg_valid  in  1  divisor update offered
cfg_div  in  WIDTH  requested divisor
cfg_ready  out  1  controller can accept cfg_div
cfg_err  out  1  one-cycle pulse: offered divisor rejected
tick  out  1  one-cycle enable, once per period
div_out  out  1  registered divided waveform
busy  out  1  state != IDLE
active_div  out  WIDTH  divisor currently in force

Behaviour:
- Clock and reset: clk is the only clock. reset is asynchronous and active-high.
- Reset values: state=IDLE, cnt=0, active_div=DEFAULT_DIV, pending=0, tick=0, div_out=0, cfg_err=0, busy=0, cfg_ready=1. Reset mid-operation aborts immediately and discards any pending divisor.
- States are IDLE, RUN and STOPPING.
- IDLE:
  - start=1 and stop=0 -> RUN, cnt<=0.
  - start=1 and stop=1 -> stay IDLE.
- RUN and STOPPING, each edge:
  - If cnt==active_div-1 (boundary): cnt<=0, tick<=1.
  - Otherwise: cnt<=cnt+1, tick<=0.
- Tick timing: with start sampled at edge 0, the first tick is high from edge active_div to edge active_div+1. Period is exactly active_div cycles.
- div_out:
  - Registered as (cnt_next < ((active_div+1)>>1)) while in RUN or STOPPING; 0 in IDLE.
  - div=4 gives 2 high / 2 low; div=3 gives 2 high / 1 low.
  - Computed from the divisor that governs cnt_next.
- Stop:
  - stop=1 in RUN -> STOPPING (stop wins over a simultaneous start).
  - STOPPING finishes the current period and emits the final tick at the boundary edge, then goes to IDLE with cnt=0 and div_out=0.
  - start=1 and stop=0 in STOPPING -> back to RUN, no break in the period.
- Config handshake: a transfer occurs on an edge where cfg_valid && cfg_ready.
  - Rejection: cfg_div < 2 is not applied. cfg_err<=1 for one cycle, no state change.
  - IDLE: active_div<=cfg_div at the accept edge. A start sampled on the same edge runs with the new divisor.
  - RUN/STOPPING: pending_div<=cfg_div, pending<=1, cfg_ready drops to 0.
  - Apply: at the next boundary edge, active_div<=pending_div and pending<=0. The following period uses the new divisor. cfg_ready is high again from the cycle after apply.
  - A transfer accepted on a boundary edge becomes pending and applies at the next boundary.
  - STOPPING boundary: the pending divisor is applied on that same edge before entering IDLE.
- cfg_ready is combinational: !pending.
- busy is registered: high in RUN and STOPPING.
- Width: cnt and active_div are WIDTH bits with no overflow (max divisor 2^WIDTH-1). Comparisons are unsigned.

Test Plan:
- Reset, then start pulse, div=2 default -> tick every 2 cycles, first at edge 2; div_out 1,0 alternating; busy=1.
- In IDLE cfg_div=5 accepted, start on the same edge -> active_div=5, ticks every 5 cycles, div_out 3 high / 2 low.
- Running div=4, cfg_div=7 at cnt=1 -> cfg_ready=0; ticks at +2 then +7 cycles; active_div changes at that boundary; cfg_ready=1 the next cycle.
- Running div=6, stop at cnt=2 -> one more tick 3 cycles later, then IDLE, busy=0, div_out=0; start+stop together in IDLE -> stays IDLE.
- cfg_div=1 and cfg_div=0 offered -> cfg_err one-cycle pulses, active_div unchanged, tick spacing unaffected.
- Running with div=9 pending, reset asserted mid-period -> all outputs at reset values immediately; after release, active_div=DEFAULT_DIV.
